serial_transmitter: RTL and testbench

- Serial transmit end of the team's 8-bit asynchronous serial link.
- Accepts a parallel byte and shifts it out on one line, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).
- Bit time is SAMPLES_PER_BIT sample periods, so the existing 16x-oversampling receiver can decode the output directly.
- Replaces the separate sample clock with an internal divider, so the block runs on a single clock.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_bit_timer.sv | 29 ++
 rtl/serial_transmitter.sv | 129 ++++++++++++
 tb/tb_serial_transmitter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by the serial link transmitter and receiver.
//   state_t   : frame FSM states (PARITY is only reachable with SERIAL_TX_PARITY_EN)
//   DEF_DATA_W: default data bits per frame
//   START_BIT / STOP_BIT: line levels for the frame delimiters
//   bit_clks(): clk cycles per serial bit from sample-period parameters
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DEF_DATA_W = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  function automatic int bit_clks(input int clks_per_sample, input int samples_per_bit);
    return clks_per_sample * samples_per_bit;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: bit-period divider. Counts 0..BIT_CLKS-1 and wraps on its own
// at each bit boundary; restart holds it at 0 so the next bit starts aligned to
// the cycle restart drops.
//   clk, rst_n : clock, async active-low reset
//   restart    : hold/clear the count at 0
//   bit_done   : high on the last cycle of each bit
module serial_bit_timer #(
  parameter int BIT_CLKS = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int             CW   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BIT_CLKS - 1);

  logic [CW-1:0] cnt;

  assign bit_done = !restart && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (restart || bit_done) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: 8N1 serial transmit end, LSB first, single clock domain.
// Each bit (start, data, optional parity, stop) holds dout for
// CLKS_PER_SAMPLE*SAMPLES_PER_BIT cycles.
//   clk, rst_n : clock, async active-low reset
//   tx_data    : byte to send, latched on accept
//   tx_en      : send request, level sensitive, ignored while busy
//   dout       : serial line, idles high
//   tx_status  : high while a frame is in progress
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 5,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_W          = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_en,
  output logic              dout,
  output logic              tx_status
);

  localparam int            BIT_CLKS = bit_clks(CLKS_PER_SAMPLE, SAMPLES_PER_BIT);
  localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [IW-1:0]     idx, idx_n;
  logic              dout_n, busy_n;
  logic              bit_done;
  logic              accept;

  assign accept = (state == IDLE) && tx_en;

  // Held in restart while idle, so the first start-bit cycle after accept
  // sees count 0 and the start edge is aligned to the accept edge.
  serial_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state == IDLE),
    .bit_done (bit_done)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_q <= 1'b0;
    else if (accept) par_q <= ^tx_data;
  end
`endif

  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    dout_n  = dout;
    busy_n  = tx_status;
    case (state)
      IDLE: begin
        dout_n = STOP_BIT;
        busy_n = 1'b0;
        if (accept) begin
          state_n = START;
          shift_n = tx_data;
          idx_n   = '0;
          dout_n  = START_BIT;
          busy_n  = 1'b1;
        end
      end
      START: if (bit_done) begin
        state_n = DATA;
        dout_n  = shift[0];
        shift_n = shift >> 1;
        idx_n   = '0;
      end
      DATA: if (bit_done) begin
        if (idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
          state_n = PARITY;
          dout_n  = par_q;
`else
          state_n = STOP;
          dout_n  = STOP_BIT;
`endif
        end else begin
          idx_n   = idx + IW'(1);
          dout_n  = shift[0];
          shift_n = shift >> 1;
        end
      end
      PARITY: if (bit_done) begin
        state_n = STOP;
        dout_n  = STOP_BIT;
      end
      STOP: if (bit_done) begin
        // Leaves through IDLE, so a held tx_en always gets one idle cycle.
        state_n = IDLE;
        dout_n  = STOP_BIT;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        dout_n  = STOP_BIT;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      idx       <= '0;
      dout      <= STOP_BIT;
      tx_status <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      idx       <= idx_n;
      dout      <= dout_n;
      tx_status <= busy_n;
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
module tb_serial_transmitter;
  import serial_pkg::*;

  localparam int BC = 80;  // 5 clks/sample * 16 samples/bit
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk, rst_n, tx_en, dout, tx_status;
  logic [7:0] tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;   // even parity of data, hand-computed
    string      name;
  } vec_t;
  vec_t vecs[5];

  serial_transmitter #(
    .CLKS_PER_SAMPLE(5),
    .SAMPLES_PER_BIT(16),
    .DATA_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .dout      (dout),
    .tx_status (tx_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit i: start, LSB-first data, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int i);
    if (i == 0)      return 1'b0;
    if (i <= 8)      return d[i-1];
    if (i == NB - 1) return 1'b1;
    return p;
  endfunction

  // Called #1 after the accept edge. Every bit must hold for exactly BC cycles
  // with tx_status high; the cycle after the frame must be idle.
  // poke_at >= 0 pulses tx_en with 8'hFF at that frame cycle.
  task automatic check_frame(input logic [7:0] d, input logic p, input int poke_at,
                             input string nm);
    int cyc;
    cyc = 0;
    for (int b = 0; b < NB; b++) begin
      int   bad;
      logic e;
      bad = 0;
      e   = exp_bit(d, p, b);
      for (int c = 0; c < BC; c++) begin
        if (dout !== e || tx_status !== 1'b1) bad++;
        if (poke_at >= 0 && cyc == poke_at) begin
          tx_data = 8'hFF;
          tx_en   = 1'b1;
        end else if (poke_at >= 0 && cyc == poke_at + 1) begin
          tx_en = 1'b0;
        end
        tick();
        cyc++;
      end
      chk($sformatf("%s bit%0d bad_cycles", nm, b), bad, 0);
    end
    chk($sformatf("%s end dout", nm), dout, 1);
    chk($sformatf("%s end tx_status", nm), tx_status, 0);
  endtask

  task automatic check_idle(input int n, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (dout !== 1'b1 || tx_status !== 1'b0) bad++;
      tick();
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, "A5"};
    vecs[1] = '{8'h00, 1'b0, "00"};
    vecs[2] = '{8'hFF, 1'b0, "FF"};
    vecs[3] = '{8'h07, 1'b1, "07"};
    vecs[4] = '{8'h81, 1'b0, "81"};

    rst_n   = 1'b1;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("reset dout", dout, 1);
    chk("reset tx_status", tx_status, 0);
    repeat (3) tick();
    chk("reset held dout", dout, 1);
    chk("reset held tx_status", tx_status, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_idle(100, "post-reset idle");

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      tx_data = vecs[v].data;
      tx_en   = 1'b1;
      tick();
      tx_en   = 1'b0;
      check_frame(vecs[v].data, vecs[v].par, -1, {"frame ", vecs[v].name});
      check_idle(5, {"gap ", vecs[v].name});
    end

    // Request while busy is ignored and no second frame follows
    tx_data = 8'h3C;
    tx_en   = 1'b1;
    tick();
    tx_en   = 1'b0;
    check_frame(8'h3C, 1'b0, 300, "busy");
    check_idle(100, "busy no second frame");

    // Back-to-back with tx_en held: one idle cycle, next start at cycle 801
    tx_data = 8'h00;
    tx_en   = 1'b1;
    tick();
    tx_data = 8'hFF;
    check_frame(8'h00, 1'b0, -1, "b2b first");
    tick();
    check_frame(8'hFF, 1'b0, -1, "b2b second");
    tx_en = 1'b0;
    tick();
    check_idle(20, "b2b after");

    // Mid-frame asynchronous reset, then a clean frame
    tx_data = 8'hA5;
    tx_en   = 1'b1;
    tick();
    tx_en   = 1'b0;
    repeat (400) tick();
    chk("pre-abort tx_status", tx_status, 1);
    rst_n = 1'b0;
    #1;
    chk("abort dout", dout, 1);
    chk("abort tx_status", tx_status, 0);
    #1 rst_n = 1'b1;
    tick();
    check_idle(10, "post-abort idle");
    tx_data = 8'hC3;
    tx_en   = 1'b1;
    tick();
    tx_en   = 1'b0;
    check_frame(8'hC3, 1'b0, -1, "after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
